prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader for the 8-bit accumulator CPU's 32-byte unified instruction/data memory.
- Accepts a framed image over a valid/ready byte interface: length byte, payload bytes, checksum byte.
- Drives the memory write port and holds the CPU in reset until a valid image is committed.
- Sits between the top-level pin mux (ui_in/uio_in) and the CPU core's memory write port.

Parameters:
- DEPTH, 32, number of memory bytes addressable.
- AW, 5, memory address width (log2 DEPTH).
- DW, 8, data/instruction width.
- BASE_ADDR, 0, first address written; subsequent addresses are modulo DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-high (rst_n=1 resets).
- start  in  1  single-cycle pulse; begins or restarts a load.
- data_in  in  DW  stream byte.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  loader can accept; a transfer occurs when data_valid & data_ready.
- mem_we  out  1  memory write strobe (registered).
- mem_addr  out  AW  memory write address (registered).
- mem_wdata  out  DW  memory write data (registered).
- cpu_hold  out  1  1 = CPU held in reset and PC forced to 0.
- done  out  1  image committed successfully.
- err  out  1  framing or checksum failure.
- load_len  out  AW+1  length of the last accepted header.

Behaviour:
- Reset values: state=IDLE, cpu_hold=1, done=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, load_len=0, data_ready=0, internal count=0, csum=0.
- States:
  - IDLE: data_ready=0. On start, go to LEN.
  - LEN: data_ready=1. Accept header byte L.
    - L==0 or L>DEPTH: go to ERR.
    - Otherwise: load_len=L, count=0, csum=0, go to DATA.
  - DATA: data_ready=1. Each accepted byte b:
    - Next cycle: mem_we=1, mem_addr=(BASE_ADDR+count) mod DEPTH, mem_wdata=b.
    - csum^=b; count++.
    - On acceptance of byte number L, go to CSUM.
  - CSUM: data_ready=1. Accept byte c.
    - c==csum: go to DONE.
    - Otherwise: go to ERR.
  - DONE: done=1, cpu_hold=0, data_ready=0. start: go to LEN.
  - ERR: err=1, cpu_hold=1, data_ready=0. start: go to LEN.
- Flag and hold timing:
  - done and err are registered and change one cycle after the deciding transfer.
  - cpu_hold deasserts in the same cycle done rises.
  - cpu_hold reasserts in the cycle after start.
- Write timing:
  - Write latency is exactly 1 cycle from transfer; at most one write per cycle.
  - mem_we is 0 in every other cycle.
  - Back-to-back transfers produce back-to-back writes.
- Start handling:
  - data_ready is forced to 0 in any cycle where start=1, so start wins over a simultaneous byte.
  - start in LEN, DATA or CSUM aborts: go to LEN, count=0, csum=0, done=0, err=0.
  - Memory already written is not rolled back.
- data_valid with data_ready=0 is ignored; data_in need not be held.
- Address wrap: BASE_ADDR+count wraps modulo DEPTH, with no error.
- Reset asserted mid-load: immediate return to reset values; the in-flight write is dropped.

Optional Feature:
- Macro: PROG_CHECKSUM_EN.
- Defined: the CSUM state and comparison exist as described above.
- Undefined: the CSUM state is removed. After the L-th data byte is accepted, go directly to DONE. err is asserted only for a bad length.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - MEM_DEPTH=32, MEM_AW=5, MEM_DW=8 constants shared with the CPU core.
- One sub-module, prog_loader_csum: running XOR accumulator with clear, enable and compare; instantiated only under PROG_CHECKSUM_EN.
- The FSM stays in prog_loader.

Test Plan:
- Reset with rst_n=1 -> cpu_hold=1, done=0, err=0, mem_we=0, data_ready=0 throughout.
- start; stream 0x03, 0x8D, 0x4E, 0xC2, 0x01 -> writes (0,0x8D), (1,0x4E), (2,0xC2), each one cycle after its transfer; then done=1, cpu_hold=0, load_len=3.
- Same image with checksum 0x00 -> err=1, cpu_hold=1, done=0; a subsequent start plus a correct image gives done=1.
- Header 0x00, then separately header 0x21 -> err=1 immediately after the header; no mem_we.
- start, 0x04, 0x11, 0x22, then start pulse, then 0x01, 0x55, 0x55 -> writes (0,0x11), (1,0x22), (0,0x55); then done=1, load_len=1.
- BASE_ADDR=30; 0x04 + 0xA0, 0xA1, 0xA2, 0xA3 with data_valid toggling randomly -> writes to 30, 31, 0, 1 only on handshakes; csum 0x00 accepted, done=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM states and memory geometry shared with the CPU core.
package prog_loader_pkg;
    localparam int MEM_DEPTH = 32;
    localparam int MEM_AW    = 5;
    localparam int MEM_DW    = 8;

    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_e;
endpackage

// File: rtl/prog_loader_csum.sv
// prog_loader_csum: running XOR of payload bytes with clear, enable and compare.
module prog_loader_csum
    import prog_loader_pkg::*;
#(
    parameter int DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] cmp,
    output logic          match
);
    logic [DW-1:0] acc_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)    acc_q <= '0;
        else if (clr) acc_q <= '0;
        else if (en)  acc_q <= acc_q ^ din;
    end

    assign match = acc_q == cmp;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader (length, payload, checksum) into CPU memory.
// Define PROG_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH     = MEM_DEPTH,
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    output logic          data_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   load_len
);
    state_e        state_q;
    logic [AW:0]   count_q, load_len_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q, cpu_hold_q, done_q, err_q;
    logic          xfer, last;

    // start masks ready so a pulse always wins over a coincident byte
    assign data_ready = (state_q == LEN || state_q == DATA || state_q == CSUM) && !start;
    assign xfer       = data_valid && data_ready;
    assign last       = (count_q + (AW+1)'(1)) == load_len_q;

`ifdef PROG_CHECKSUM_EN
    logic csum_ok;

    prog_loader_csum #(.DW(DW)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start || (state_q == LEN && xfer)),
        .en    (state_q == DATA && xfer),
        .din   (data_in),
        .cmp   (data_in),
        .match (csum_ok)
    );
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            load_len_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (start) begin
                state_q    <= LEN;
                count_q    <= '0;
                cpu_hold_q <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else if (xfer) begin
                case (state_q)
                    LEN: begin
                        if (data_in == '0 || int'(data_in) > DEPTH) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= DATA;
                            load_len_q <= (AW+1)'(data_in);
                            count_q    <= '0;
                        end
                    end
                    DATA: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= AW'((BASE_ADDR + int'(count_q)) % DEPTH);
                        mem_wdata_q <= data_in;
                        count_q     <= count_q + (AW+1)'(1);
                        if (last) begin
`ifdef PROG_CHECKSUM_EN
                            state_q <= CSUM;
`else
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
`endif
                        end
                    end
`ifdef PROG_CHECKSUM_EN
                    CSUM: begin
                        if (csum_ok) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load_len  = load_len_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: two loaders (base 0 and base 30) on one stream, checked every cycle against a frame model.
module tb_prog_loader;
    logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, data_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] rdy, we, hold, dn, er;
    logic [4:0] addr [2];
    logic [7:0] wd [2];
    logic [5:0] ll [2];

    always #5 clk = ~clk;

    prog_loader #(.BASE_ADDR(0)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]),
        .cpu_hold(hold[0]), .done(dn[0]), .err(er[0]), .load_len(ll[0]));

    prog_loader #(.BASE_ADDR(30)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd[1]),
        .cpu_hold(hold[1]), .done(dn[1]), .err(er[1]), .load_len(ll[1]));

    int tests = 0, fails = 0;
    int wq0 [$], wq1 [$];

    // model phases: 0 idle, 1 want length, 2 payload, 3 want checksum, 4 committed, 5 failed
    int ph [2], len [2], cnt [2], sum [2], m_addr [2], m_wd [2], m_ll [2];
    bit m_we [2], m_hold [2], m_done [2], m_err [2];
    bit mx;

    always @(posedge clk or posedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                ph[k] = 0; len[k] = 0; cnt[k] = 0; sum[k] = 0; m_addr[k] = 0; m_wd[k] = 0; m_ll[k] = 0;
                m_we[k] = 0; m_hold[k] = 1; m_done[k] = 0; m_err[k] = 0;
            end else begin
                mx = data_valid && ph[k] >= 1 && ph[k] <= 3 && !start;
                m_we[k] = 0;
                if (start) begin
                    ph[k] = 1; cnt[k] = 0; sum[k] = 0; m_done[k] = 0; m_err[k] = 0; m_hold[k] = 1;
                end else if (mx) begin
                    if (ph[k] == 1) begin
                        if (data_in == 0 || int'(data_in) > 32) begin
                            ph[k] = 5; m_err[k] = 1;
                        end else begin
                            ph[k] = 2; len[k] = data_in; m_ll[k] = data_in; cnt[k] = 0; sum[k] = 0;
                        end
                    end else if (ph[k] == 2) begin
                        m_we[k] = 1;
                        m_addr[k] = ((k ? 30 : 0) + cnt[k]) % 32;
                        m_wd[k] = data_in;
                        sum[k] = sum[k] ^ int'(data_in);
                        cnt[k]++;
                        if (cnt[k] == len[k]) begin
`ifdef PROG_CHECKSUM_EN
                            ph[k] = 3;
`else
                            ph[k] = 4; m_done[k] = 1; m_hold[k] = 0;
`endif
                        end
                    end else if (int'(data_in) == sum[k]) begin
                        ph[k] = 4; m_done[k] = 1; m_hold[k] = 0;
                    end else begin
                        ph[k] = 5; m_err[k] = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", n, k, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("data_ready", k, 32'(rdy[k]), 32'(ph[k] >= 1 && ph[k] <= 3 && !start));
            chk("mem_we", k, 32'(we[k]), 32'(m_we[k]));
            chk("mem_addr", k, 32'(addr[k]), m_addr[k]);
            chk("mem_wdata", k, 32'(wd[k]), m_wd[k]);
            chk("cpu_hold", k, 32'(hold[k]), 32'(m_hold[k]));
            chk("done", k, 32'(dn[k]), 32'(m_done[k]));
            chk("err", k, 32'(er[k]), 32'(m_err[k]));
            chk("load_len", k, 32'(ll[k]), m_ll[k]);
        end
        if (we[0]) wq0.push_back(int'(addr[0]) * 256 + int'(wd[0]));
        if (we[1]) wq1.push_back(int'(addr[1]) * 256 + int'(wd[1]));
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic pulse;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 50) begin
            data_valid = rnd ? 1'($urandom % 2) : 1'b1;
            data_in = data_valid ? b : 8'($urandom);
            @(negedge clk);
            got = data_valid && rdy[0];
            tick;
            n++;
        end
        data_valid = 1'b0;
        data_in = 8'($urandom);
        if (!got) chk("handshake_timeout", 0, 32'(got), 1);
    endtask

    task automatic send_cs(input logic [7:0] b);
`ifdef PROG_CHECKSUM_EN
        send(b, 0);
`else
        data_valid = 1'b1; data_in = b; tick; data_valid = 1'b0;
`endif
    endtask

    task automatic expw(input int k, input string n, input int num, input int e [4]);
        int got, act;
        got = k ? wq1.size() : wq0.size();
        chk({n, "_count"}, k, got, num);
        for (int i = 0; i < num; i++) begin
            act = i < got ? (k ? wq1[i] : wq0[i]) : -1;
            chk({n, "_write"}, k, act, e[i]);
        end
    endtask

    task automatic clearq;
        wq0.delete(); wq1.delete();
    endtask

    task automatic image(input logic [7:0] cs);
        send(8'h03, 0); send(8'h8D, 0); send(8'h4E, 0); send(8'hC2, 0); send_cs(cs);
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_hold", 0, 32'(hold[0]), 1);
        chk("rst_ready", 0, 32'(rdy[0]), 0);
        chk("rst_we", 0, 32'(we[0]), 0);
        rst_n = 1'b0;
        tick;

        clearq; pulse; image(8'h01); tick;
        expw(0, "s1", 3, '{32'h008D, 32'h014E, 32'h02C2, 0});
        expw(1, "s1", 3, '{32'h1E8D, 32'h1F4E, 32'h00C2, 0});
        chk("s1_done", 0, 32'(dn[0]), 1);
        chk("s1_hold", 0, 32'(hold[0]), 0);
        chk("s1_len", 0, 32'(ll[0]), 3);

        pulse;
        chk("s2_hold_after_start", 0, 32'(hold[0]), 1);
        image(8'h00); tick;
`ifdef PROG_CHECKSUM_EN
        chk("s2_err", 0, 32'(er[0]), 1);
        chk("s2_done", 0, 32'(dn[0]), 0);
        chk("s2_hold", 0, 32'(hold[0]), 1);
`else
        chk("s2_done", 0, 32'(dn[0]), 1);
`endif
        pulse; image(8'h01); tick;
        chk("s2_redo_done", 0, 32'(dn[0]), 1);

        clearq; pulse; send(8'h00, 0); tick;
        chk("s3_len0_err", 0, 32'(er[0]), 1);
        pulse; send(8'h21, 0); tick;
        chk("s3_len33_err", 1, 32'(er[1]), 1);
        expw(0, "s3", 0, '{0, 0, 0, 0});

        clearq; pulse; send(8'h04, 0); send(8'h11, 0); send(8'h22, 0);
        pulse; send(8'h01, 0); send(8'h55, 0); send_cs(8'h55); tick;
        expw(0, "s4", 3, '{32'h0011, 32'h0122, 32'h0055, 0});
        expw(1, "s4", 3, '{32'h1E11, 32'h1F22, 32'h1E55, 0});
        chk("s4_done", 0, 32'(dn[0]), 1);
        chk("s4_len", 0, 32'(ll[0]), 1);

        clearq; pulse; send(8'h04, 1);
        send(8'hA0, 1); send(8'hA1, 1); send(8'hA2, 1); send(8'hA3, 1); send_cs(8'h00); tick;
        expw(1, "s5", 4, '{32'h1EA0, 32'h1FA1, 32'h00A2, 32'h01A3});
        expw(0, "s5", 4, '{32'h00A0, 32'h01A1, 32'h02A2, 32'h03A3});
        chk("s5_done", 1, 32'(dn[1]), 1);

        pulse; send(8'h05, 0); send(8'h01, 0);
        rst_n = 1'b1; #1;
        chk("s6_write_dropped", 0, 32'(we[0]), 0);
        chk("s6_hold", 0, 32'(hold[0]), 1);
        tick; rst_n = 1'b0; tick;

        repeat (3000) begin
            start = ($urandom % 24 == 0) || ((ph[0] >= 4 || ph[0] == 0) && $urandom % 4 == 0);
            data_valid = $urandom % 3 != 0;
            if (ph[0] == 1)      data_in = ($urandom % 10 == 0) ? 8'($urandom) : 8'(1 + $urandom % 6);
            else if (ph[0] == 3) data_in = ($urandom % 4 != 0) ? 8'(sum[0]) : 8'($urandom);
            else                 data_in = 8'($urandom);
            tick;
        end
        start = 1'b0; data_valid = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
